// File: rtl/alu_unit.sv
// Multi-cycle ALU on a shared tri-state CPU data bus.
// Single-cycle arithmetic/logic ops; shifts take one cycle per bit position.

module alu_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] data,
  input  logic             ialu,
  input  logic             isel,
  input  logic             ealu,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic [WIDTH-1:0] o_alu
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_cf_c;
  logic               alu_valid_c;
  logic               is_shift_c;
  logic               shl_c;
  logic [WIDTH-1:0]   shift_next_c;
  logic               shift_out_c;
  logic [CNT_W-1:0]   k_c;

  // Single-cycle datapath for ops 0-6; valid flags which ops write the result.
  always_comb begin
    sum_c       = {1'b0, a_q} + {1'b0, b_q};
    alu_res_c   = a_q;
    alu_cf_c    = 1'b0;
    alu_valid_c = 1'b1;
    case (op_q)
      OP_PASS: alu_res_c = a_q;
      OP_ADD: begin
        alu_res_c = sum_c[WIDTH-1:0];
        alu_cf_c  = sum_c[WIDTH];
      end
      OP_SUB: begin
        alu_res_c = a_q - b_q;
        alu_cf_c  = (a_q < b_q);
      end
      OP_XOR:  alu_res_c = a_q ^ b_q;
      OP_OR:   alu_res_c = a_q | b_q;
      OP_AND:  alu_res_c = a_q & b_q;
      OP_NOT:  alu_res_c = ~a_q;
      default: alu_valid_c = 1'b0;
    endcase
  end

  // One-bit shift step; the bit leaving the register becomes the carry.
  always_comb begin
    is_shift_c   = (op_q == OP_SHL) || (op_q == OP_SHR);
    shl_c        = (op_q == OP_SHL);
    k_c          = b_q[CNT_W-1:0];
    shift_next_c = shl_c ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
    shift_out_c  = shl_c ? shreg_q[WIDTH-1] : shreg_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      zf       <= 1'b0;
      cf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Operand capture shares the edge with start so the new value is used.
          if (ialu) begin
            if (isel) b_q <= data;
            else      a_q <= data;
          end
          if (start) begin
            op_q  <= op;
            state <= EXEC;
            busy  <= 1'b1;
          end
        end

        EXEC: begin
          if (is_shift_c) begin
            shreg_q <= a_q;
            cnt_q   <= k_c;
            if (k_c == '0) begin
              result_q <= a_q;
              zf       <= (a_q == '0);
              cf       <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= SHIFT;
            end
          end else begin
            if (alu_valid_c) begin
              result_q <= alu_res_c;
              zf       <= (alu_res_c == '0);
              cf       <= alu_cf_c;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          shreg_q <= shift_next_c;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= shift_next_c;
            zf       <= (shift_next_c == '0);
            cf       <= shift_out_c;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_alu = result_q;
  // Bus is released during reset as well as whenever ealu is low.
  assign data  = (ealu && !reset) ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus random ops
// compared against an arithmetic reference model.

module tb_alu_unit;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  wire  [W-1:0] data;
  logic [W-1:0] drv_val;
  logic         drv_en;
  logic         ialu;
  logic         isel;
  logic         ealu;
  logic [3:0]   op;
  logic         start;
  logic         busy;
  logic         done;
  logic         zf;
  logic         cf;
  logic [W-1:0] o_alu;

  int checks;
  int errors;

  // Reference model state
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_res;
  logic         m_zf;
  logic         m_cf;

  alu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .ialu  (ialu),
    .isel  (isel),
    .ealu  (ealu),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .zf    (zf),
    .cf    (cf),
    .o_alu (o_alu)
  );

  // A released bus reads as all ones through the weak pull-up.
  pullup (data);
  assign data = drv_en ? drv_val : {W{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void apply_model(input logic [3:0] o, output int lat);
    int k;
    int s;
    logic [W-1:0] tmp;
    k   = int'(m_b[3:0]);
    lat = 1;
    case (o)
      4'd0: begin m_res = m_a; m_cf = 1'b0; end
      4'd1: begin
        s     = int'(m_a) + int'(m_b);
        m_res = W'(s);
        m_cf  = (s >= (1 << W));
      end
      4'd2: begin m_res = m_a - m_b; m_cf = (m_a < m_b); end
      4'd3: begin m_res = m_a ^ m_b; m_cf = 1'b0; end
      4'd4: begin m_res = m_a | m_b; m_cf = 1'b0; end
      4'd5: begin m_res = m_a & m_b; m_cf = 1'b0; end
      4'd6: begin m_res = ~m_a;      m_cf = 1'b0; end
      4'd7: begin
        m_res = m_a << k;
        tmp   = (k == 0) ? '0 : (m_a >> (int'(W) - k));
        m_cf  = tmp[0];
        lat   = 1 + k;
      end
      4'd8: begin
        m_res = m_a >> k;
        tmp   = (k == 0) ? '0 : (m_a >> (k - 1));
        m_cf  = tmp[0];
        lat   = 1 + k;
      end
      default: return;
    endcase
    m_zf = (m_res == '0);
  endfunction

  // Entered and left just after a falling edge.
  task automatic load(input logic sel, input logic [W-1:0] val);
    ialu = 1'b1; isel = sel; drv_en = 1'b1; drv_val = val;
    @(negedge clk);
    ialu = 1'b0; drv_en = 1'b0;
    if (sel) m_b = val; else m_a = val;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input bit co_load,
                        input logic sel, input logic [W-1:0] val, input bit inject);
    int lat;
    int n;
    logic [W-1:0] prev;
    prev  = m_res;
    op    = o;
    start = 1'b1;
    if (co_load) begin
      ialu = 1'b1; isel = sel; drv_en = 1'b1; drv_val = val;
      if (sel) m_b = val; else m_a = val;
    end
    apply_model(o, lat);
    @(negedge clk);
    start = 1'b0; ialu = 1'b0; drv_en = 1'b0;
    check({tag, "_busy"}, W'(busy), W'(1));
    n = 0;
    while (!done && n < 40) begin
      check({tag, "_hold"}, o_alu, prev);
      @(negedge clk);
      n++;
      if (inject && n == 1) begin
        start = 1'b1; op = 4'd1;
        ialu = 1'b1; isel = 1'b0; drv_en = 1'b1; drv_val = 16'hAAAA;
      end else begin
        start = 1'b0; ialu = 1'b0; drv_en = 1'b0;
      end
    end
    start = 1'b0; ialu = 1'b0; drv_en = 1'b0;
    check({tag, "_lat"}, W'(n), W'(lat));
    check({tag, "_res"}, o_alu, m_res);
    check({tag, "_zf"}, W'(zf), W'(m_zf));
    check({tag, "_cf"}, W'(cf), W'(m_cf));
    check({tag, "_idle"}, W'(busy), W'(0));
    @(negedge clk);
    check({tag, "_done1"}, W'(done), W'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_done;
    checks = 0; errors = 0;
    reset = 1'b1; ialu = 1'b0; isel = 1'b0; ealu = 1'b1; op = '0; start = 1'b0;
    drv_en = 1'b0; drv_val = '0;
    m_a = '0; m_b = '0; m_res = '0; m_zf = 1'b0; m_cf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res", o_alu, 16'h0000);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_flags", W'({zf, cf}), W'(0));
    check("rst_bus_z", data, 16'hFFFF);
    reset = 1'b0; ealu = 1'b0;
    @(negedge clk);

    // Basic ADD
    load(1'b0, 16'h0003); load(1'b1, 16'h0005);
    run_op("add", 4'd1, 1'b0, 1'b0, '0, 1'b0);
    check("add_val", o_alu, 16'h0008);

    // ADD carry and zero, then SUB borrow
    load(1'b0, 16'hFFFF); load(1'b1, 16'h0001);
    run_op("add_c", 4'd1, 1'b0, 1'b0, '0, 1'b0);
    check("add_c_zc", W'({zf, cf}), W'(2'b11));
    load(1'b0, 16'h0002); load(1'b1, 16'h0003);
    run_op("sub_b", 4'd2, 1'b0, 1'b0, '0, 1'b0);
    check("sub_b_val", o_alu, 16'hFFFF);

    // Shifts: multi-cycle, one-bit, and zero count
    load(1'b0, 16'h8001); load(1'b1, 16'h0003);
    run_op("shl3", 4'd7, 1'b0, 1'b0, '0, 1'b0);
    check("shl3_val", o_alu, 16'h0008);
    load(1'b1, 16'h0001);
    run_op("shr1", 4'd8, 1'b0, 1'b0, '0, 1'b0);
    check("shr1_val", o_alu, 16'h4000);
    load(1'b1, 16'h0000);
    run_op("shl0", 4'd7, 1'b0, 1'b0, '0, 1'b0);
    check("shl0_val", o_alu, 16'h8001);

    // Capture together with start, then start/ialu during SHIFT ignored
    load(1'b0, 16'h0001);
    run_op("coload", 4'd1, 1'b1, 1'b1, 16'h0002, 1'b0);
    check("coload_val", o_alu, 16'h0003);
    load(1'b0, 16'h8001); load(1'b1, 16'h0003);
    run_op("inj", 4'd7, 1'b0, 1'b0, '0, 1'b1);
    run_op("inj_a", 4'd0, 1'b0, 1'b0, '0, 1'b0);
    run_op("inj_ab", 4'd1, 1'b0, 1'b0, '0, 1'b0);
    check("inj_ab_val", o_alu, 16'h8004);

    // Bus drive follows ealu
    ealu = 1'b1; #1;
    check("bus_drv", data, m_res);
    ealu = 1'b0; #1;
    check("bus_z", data, 16'hFFFF);
    @(negedge clk);

    // Reserved op leaves result and flags alone
    load(1'b0, 16'h1234);
    run_op("pass", 4'd0, 1'b0, 1'b0, '0, 1'b0);
    run_op("rsv12", 4'd12, 1'b0, 1'b0, '0, 1'b0);
    check("rsv12_val", o_alu, 16'h1234);

    // Reset in the middle of a long shift
    load(1'b0, 16'h8001); load(1'b1, 16'h000F);
    op = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    reset = 1'b1; ealu = 1'b1; #1;
    check("mid_rst_res", o_alu, 16'h0000);
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_flags", W'({zf, cf}), W'(0));
    check("mid_rst_bus_z", data, 16'hFFFF);
    @(negedge clk);
    reset = 1'b0; #1;
    check("post_rst_bus", data, o_alu);
    ealu = 1'b0; #1;
    check("post_rst_z", data, 16'hFFFF);
    m_a = '0; m_b = '0; m_res = '0; m_zf = 1'b0; m_cf = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst_no_done", W'(seen_done), W'(0));
    run_op("rst_a", 4'd0, 1'b0, 1'b0, '0, 1'b0);
    run_op("rst_ab", 4'd1, 1'b0, 1'b0, '0, 1'b0);

    // Random operands and opcodes, including reserved ones
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) load(1'b0, W'($urandom));
      if ($urandom_range(0, 1) == 1) load(1'b1, W'($urandom));
      run_op("rnd", 4'($urandom_range(0, 15)), 1'b0, 1'b0, '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
